// File: rtl/io_window_decoder.sv
// io_window_decoder: programmable Z80 I/O window decoder with config ports and wait-state FSM
module io_window_decoder #(
  parameter int NUM_CH = 8,
  parameter int MAX_WAIT = 7,
  parameter logic [7:0] CFG_PORT = 8'h7E
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        address,
  input  logic [7:0]        data_in,
  input  logic              iowrite,
  input  logic              ioread,
  output logic [NUM_CH-1:0] cs_wr,
  output logic [NUM_CH-1:0] cs_rd,
  output logic              cfg_rd_en,
  output logic [7:0]        cfg_rd_data,
  output logic              io_wait,
  output logic              miss
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state;
  logic [7:0] base [NUM_CH];
  logic [7:0] mask [NUM_CH];
  logic [4:0] ctrl [NUM_CH];
  logic [7:0] idx;
  logic [2:0] cnt;
  logic strb_d;
  logic strb, start, illegal, is_idx, is_dat, hit;
  logic [NUM_CH-1:0] onehot;
  logic [2:0] hit_w, w_in;
  logic [7:0] reg_val;
  always_comb begin
    strb = ioread | iowrite;
    start = strb & ~strb_d;
    illegal = ioread & iowrite;
    is_idx = address == CFG_PORT;
    is_dat = address == CFG_PORT + 8'd1;
    w_in = int'(data_in[4:2]) > MAX_WAIT ? 3'(MAX_WAIT) : data_in[4:2];
    onehot = '0;
    hit = 1'b0;
    hit_w = 3'd0;
    // Scan downward so the lowest hitting window overwrites any higher one.
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (((address ^ base[i]) & mask[i]) == 8'h00 && (ioread ? ctrl[i][0] : ctrl[i][1])) begin
        onehot = '0;
        onehot[i] = 1'b1;
        hit = 1'b1;
        hit_w = ctrl[i][4:2];
      end
    reg_val = 8'h00;
    for (int i = 0; i < NUM_CH; i++)
      if (idx[7:2] == 6'(i))
        reg_val = idx[1:0] == 2'd0 ? base[i] : idx[1:0] == 2'd1 ? mask[i] :
                  idx[1:0] == 2'd2 ? {3'b000, ctrl[i]} : 8'h00;
  end
  assign io_wait = state == WAIT;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 3'd0;
      strb_d <= 1'b1;
      idx <= 8'h00;
      cs_wr <= '0;
      cs_rd <= '0;
      cfg_rd_en <= 1'b0;
      cfg_rd_data <= 8'h00;
      miss <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        base[i] <= 8'h00;
        mask[i] <= 8'hFF;
        ctrl[i] <= 5'd0;
      end
    end else begin
      strb_d <= strb;
      miss <= start & (illegal | (~(is_idx | is_dat) & ~hit));
      if (!strb) begin
        state <= IDLE;
        cnt <= 3'd0;
        cs_wr <= '0;
        cs_rd <= '0;
        cfg_rd_en <= 1'b0;
      end else if (start) begin
        if (illegal) state <= HOLD;
        else if (is_idx | is_dat) begin
          state <= HOLD;
          cfg_rd_en <= ioread;
          if (ioread) cfg_rd_data <= is_idx ? idx : reg_val;
          if (is_idx && iowrite) idx <= data_in;
          if (is_dat) idx <= idx + 8'd1;
          for (int i = 0; i < NUM_CH; i++)
            if (is_dat && iowrite && idx[7:2] == 6'(i)) begin
              if (idx[1:0] == 2'd0) base[i] <= data_in;
              else if (idx[1:0] == 2'd1) mask[i] <= data_in;
              else if (idx[1:0] == 2'd2) ctrl[i] <= {w_in, data_in[1:0]};
            end
        end else begin
          cs_wr <= iowrite ? onehot : '0;
          cs_rd <= ioread ? onehot : '0;
          state <= hit && hit_w != 3'd0 ? WAIT : HOLD;
          cnt <= hit ? hit_w : 3'd0;
        end
      end else if (state == WAIT) begin
        if (cnt == 3'd1) begin
          state <= HOLD;
          cnt <= 3'd0;
        end else cnt <= cnt - 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_io_window_decoder.sv
// tb_io_window_decoder: scoreboard bench; stimulus queues expected per-cycle outputs, monitor pops on activity
module tb_io_window_decoder;
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] address = 8'h00, data_in = 8'h00;
  logic iowrite = 1'b0, ioread = 1'b0;
  logic [7:0] cs_wr, cs_rd, cfg_rd_data;
  logic cfg_rd_en, io_wait, miss;
  int n_chk = 0, n_pass = 0;
  typedef struct packed {
    logic [7:0] cw;
    logic [7:0] cr;
    logic       en;
    logic [7:0] dat;
    logic       wt;
    logic       ms;
  } obs_t;
  obs_t exp_q[$];
  io_window_decoder dut (
    .clock(clock), .reset(reset), .address(address), .data_in(data_in),
    .iowrite(iowrite), .ioread(ioread), .cs_wr(cs_wr), .cs_rd(cs_rd),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_data(cfg_rd_data), .io_wait(io_wait), .miss(miss)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    obs_t o, e;
    o = '{cw: cs_wr, cr: cs_rd, en: cfg_rd_en, dat: cfg_rd_en ? cfg_rd_data : 8'h00, wt: io_wait, ms: miss};
    if (o != '0) begin
      n_chk++;
      if (exp_q.size() == 0)
        $display("FAIL unexpected_output: got cw=%h cr=%h en=%b dat=%h wait=%b miss=%b, want no activity",
                 o.cw, o.cr, o.en, o.dat, o.wt, o.ms);
      else begin
        e = exp_q.pop_front();
        if (o == e) n_pass++;
        else $display("FAIL obs @%0t: got cw=%h cr=%h en=%b dat=%h wait=%b miss=%b, want cw=%h cr=%h en=%b dat=%h wait=%b miss=%b",
                      $time, o.cw, o.cr, o.en, o.dat, o.wt, o.ms, e.cw, e.cr, e.en, e.dat, e.wt, e.ms);
      end
    end
  end
  task automatic push_exp(input int n, input logic [7:0] ecw, ecr, input logic een,
                          input logic [7:0] edat, input int ew, input logic ems);
    for (int k = 0; k < n; k++) begin
      obs_t e;
      e = '{cw: ecw, cr: ecr, en: een, dat: een ? edat : 8'h00, wt: k < ew, ms: ems && k == 0};
      if (e != '0) exp_q.push_back(e);
    end
  endtask
  task automatic cyc(input logic rd, wr, input logic [7:0] a, d, input int n,
                     input logic [7:0] ecw, ecr, input logic een, input logic [7:0] edat,
                     input int ew, input logic ems);
    push_exp(n, ecw, ecr, een, edat, ew, ems);
    @(posedge clock);
    #1 address = a; data_in = d; ioread = rd; iowrite = wr;
    repeat (n) @(posedge clock);
    #1 ioread = 1'b0; iowrite = 1'b0;
  endtask
  task automatic wr_port(input logic [7:0] a, d);
    cyc(1'b0, 1'b1, a, d, 1, 8'h00, 8'h00, 1'b0, 8'h00, 0, 1'b0);
  endtask
  task automatic rd_cfg(input logic [7:0] v);
    cyc(1'b1, 1'b0, 8'h7F, 8'h00, 1, 8'h00, 8'h00, 1'b1, v, 0, 1'b0);
  endtask
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_chk++;
    if ({cs_wr, cs_rd, cfg_rd_en, cfg_rd_data, io_wait, miss} == '0) n_pass++;
    else $display("FAIL reset_outputs: got %h, want 0", {cs_wr, cs_rd, cfg_rd_en, cfg_rd_data, io_wait, miss});
    @(posedge clock);
    #1 reset = 1'b0;
    cyc(1'b1, 1'b0, 8'h40, 8'h00, 1, 8'h00, 8'h00, 1'b0, 8'h00, 0, 1'b1);
    wr_port(8'h7E, 8'h04);
    wr_port(8'h7F, 8'h30);
    wr_port(8'h7F, 8'h3C);
    wr_port(8'h7F, 8'h03);
    wr_port(8'h7E, 8'h04);
    rd_cfg(8'h30);
    rd_cfg(8'h3C);
    rd_cfg(8'h03);
    // index is now 07 (reserved); the next data write is dropped and lands window 2 at 08
    wr_port(8'h7F, 8'hAA);
    wr_port(8'h7F, 8'h50);
    wr_port(8'h7F, 8'hF0);
    wr_port(8'h7F, 8'h0D);
    wr_port(8'h7E, 8'h00);
    wr_port(8'h7F, 8'h30);
    wr_port(8'h7F, 8'hF0);
    wr_port(8'h7F, 8'h03);
    cyc(1'b0, 1'b1, 8'h32, 8'h00, 3, 8'h01, 8'h00, 1'b0, 8'h00, 0, 1'b0);
    cyc(1'b0, 1'b1, 8'h42, 8'h00, 1, 8'h00, 8'h00, 1'b0, 8'h00, 0, 1'b1);
    cyc(1'b1, 1'b0, 8'h37, 8'h00, 2, 8'h00, 8'h01, 1'b0, 8'h00, 0, 1'b0);
    wr_port(8'h7E, 8'h02);
    wr_port(8'h7F, 8'h02);
    wr_port(8'h7E, 8'h02);
    rd_cfg(8'h02);
    cyc(1'b1, 1'b0, 8'h31, 8'h00, 2, 8'h00, 8'h02, 1'b0, 8'h00, 0, 1'b0);
    cyc(1'b1, 1'b0, 8'h55, 8'h00, 6, 8'h00, 8'h04, 1'b0, 8'h00, 3, 1'b0);
    wr_port(8'h7E, 8'h0A);
    rd_cfg(8'h0D);
    wr_port(8'h7E, 8'h0A);
    wr_port(8'h7F, 8'h1D);
    cyc(1'b1, 1'b0, 8'h55, 8'h00, 2, 8'h00, 8'h04, 1'b0, 8'h00, 7, 1'b0);
    cyc(1'b1, 1'b0, 8'h55, 8'h00, 9, 8'h00, 8'h04, 1'b0, 8'h00, 7, 1'b0);
    wr_port(8'h7E, 8'h08);
    cyc(1'b1, 1'b1, 8'h7F, 8'h00, 2, 8'h00, 8'h00, 1'b0, 8'h00, 0, 1'b1);
    rd_cfg(8'h50);
    cyc(1'b1, 1'b1, 8'h55, 8'h00, 2, 8'h00, 8'h00, 1'b0, 8'h00, 0, 1'b1);
    push_exp(2, 8'h00, 8'h04, 1'b0, 8'h00, 2, 1'b0);
    @(posedge clock);
    #1 address = 8'h55; ioread = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 ioread = 1'b0;
    cyc(1'b1, 1'b0, 8'h55, 8'h00, 1, 8'h00, 8'h00, 1'b0, 8'h00, 0, 1'b1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL missing_outputs: got %0d expected observations left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
